dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Memory-side responder for the core's data-memory port.
- Accepts word-aligned load/store requests over a valid/ready request channel.
- Services each request from an internal word-addressed RAM after a programmable wait-state count, then returns data or an error over a valid/ready response channel.
- Sits between the core's load/store path and on-chip data RAM; handles one outstanding request at a time.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words in the RAM; power of two, at least 2.
- BASE_ADDR, 32'h0000_0000, byte address mapped to word 0; must be 4-byte aligned.
- LATENCY, 2, wait-state cycles between request accept and response valid; range 0..15.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  reset, asynchronous, active-high.
- req_valid  input  1  initiator presents a request.
- req_ready  output  1  responder can accept a request.
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data.
- req_be  input  4  byte enables for stores; bit i enables byte lane i (bits 8i+7:8i).
- rsp_valid  output  1  response present.
- rsp_ready  input  1  initiator accepts the response.
- rsp_rdata  output  32  load data; 0 for stores and for errors.
- rsp_err  output  1  request was misaligned or out of range.

Behaviour:
- Reset values: req_ready=0 while reset is asserted, then 1 in IDLE. rsp_valid=0, rsp_rdata=0, rsp_err=0. FSM=IDLE, wait counter=0.
- Reset does not clear RAM contents.
- FSM states:
  - IDLE: req_ready=1.
  - WAIT: count down the wait states.
  - RESP: rsp_valid=1.
- Accept: a request is accepted on a rising edge where req_valid=1 and req_ready=1 in IDLE. At that edge, latch we/addr/wdata/be.
  - If LATENCY=0, go to RESP.
  - Otherwise, load counter=LATENCY-1 and go to WAIT.
- WAIT: decrement the counter each cycle; go to RESP on the edge where the counter is 0.
- Result: rsp_valid rises exactly LATENCY+1 cycles after the accept edge.
- Error check: a request is in error if latched addr[1:0]!=0, addr<BASE_ADDR, or (addr-BASE_ADDR)>>2 >= DEPTH_WORDS.
- Word index: (addr-BASE_ADDR)>>2, in 32-bit arithmetic with no wrap.
- Commit: on the edge entering RESP, the RAM access is performed:
  - Load: rsp_rdata = full word, req_be ignored.
  - Store: write only the enabled byte lanes; rsp_rdata=0.
  - Error: no RAM write, rsp_rdata=0, rsp_err=1.
  - A store with req_be=0 is legal and changes nothing.
- RESP: rsp_valid, rsp_rdata and rsp_err are held stable until rsp_ready=1 at a rising edge.
  - At that edge, clear rsp_valid/rsp_rdata/rsp_err and return to IDLE.
  - req_ready=1 in the following cycle, so the minimum initiation interval is LATENCY+2 cycles.
- req_ready=0 in WAIT and RESP. Request inputs are ignored there; a held req_valid is accepted only after returning to IDLE.
- Requests are serviced strictly in order, so a load after a store to the same word returns the stored data.
- Reset mid-operation: the FSM returns to IDLE and the pending response is dropped. A store not yet committed (still in WAIT) is lost; a committed store persists.
- rsp_ready while rsp_valid=0 has no effect.

Test Plan:
- LATENCY=2: store addr 0x10, wdata 0xDEADBEEF, be 4'hF, then load 0x10 -> store response rsp_valid 3 cycles after accept with rdata=0, err=0; load returns 0xDEADBEEF.
- Byte enables: preload 0x20 with 0x11223344; store 0xAABBCCDD with be 4'b0101; load 0x20 -> 0x11BB33DD.
- Errors: load 0x22, and load BASE_ADDR+4*DEPTH_WORDS -> rsp_err=1, rdata=0; a following load of an untouched aligned address shows no side effect.
- Back-pressure: hold rsp_ready=0 for 5 cycles -> rsp_valid/rdata/err stable, req_ready=0 throughout; req_ready=1 one cycle after the rsp_ready handshake.
- LATENCY=0: back-to-back loads with req_valid held high -> rsp_valid one cycle after each accept, accepts spaced 2 cycles apart.
- Reset during WAIT of a store to 0x30 (previously 0x0) -> outputs at reset values, IDLE; a later load of 0x30 returns 0x0.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one word-aligned load/store at a time, waits
// LATENCY cycles, commits the access to on-chip RAM and holds the response until it is taken.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0]  CNT_INIT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_next;
    logic        w_commit;
    logic        w_accept;

    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_be;

    logic        w_c_we;
    logic [31:0] w_c_addr;
    logic [31:0] w_c_wdata;
    logic [3:0]  w_c_be;
    logic [31:0] w_off;
    logic        w_err;
    logic [IDX_W-1:0] w_idx;

    logic        r_rsp_err;
    logic        r_rsp_load;
    logic [31:0] w_rd_word;

    assign req_ready = (r_state == ST_IDLE) && !reset;
    assign w_accept  = req_valid && req_ready;

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_commit     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (LATENCY == 0) begin
                        w_state_next = ST_RESP;
                        w_commit     = 1'b1;
                    end else begin
                        w_state_next = ST_WAIT;
                        w_cnt_next   = CNT_INIT;
                    end
                end
            end
            ST_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_state_next = ST_RESP;
                    w_commit     = 1'b1;
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // With zero latency the commit happens on the accept edge, so use the live request.
    assign w_c_we    = (r_state == ST_IDLE) ? req_we    : r_we;
    assign w_c_addr  = (r_state == ST_IDLE) ? req_addr  : r_addr;
    assign w_c_wdata = (r_state == ST_IDLE) ? req_wdata : r_wdata;
    assign w_c_be    = (r_state == ST_IDLE) ? req_be    : r_be;

    assign w_off = w_c_addr - BASE_ADDR;
    assign w_err = (w_c_addr[1:0] != 2'b00) || (w_c_addr < BASE_ADDR)
                   || ((w_off >> 2) >= DEPTH_WORDS);
    assign w_idx = w_off[IDX_W+1:2];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_cnt      <= 4'd0;
            r_we       <= 1'b0;
            r_addr     <= 32'd0;
            r_wdata    <= 32'd0;
            r_be       <= 4'd0;
            r_rsp_err  <= 1'b0;
            r_rsp_load <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            if (w_accept) begin
                r_we    <= req_we;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
                r_be    <= req_be;
            end
            if (w_commit) begin
                r_rsp_err  <= w_err;
                r_rsp_load <= !w_err && !w_c_we;
            end else if ((r_state == ST_RESP) && rsp_ready) begin
                r_rsp_err  <= 1'b0;
                r_rsp_load <= 1'b0;
            end
        end
    end

    // One byte-wide RAM per lane keeps byte-enable writes single-driver per array.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] r_mem [DEPTH_WORDS];
            logic [7:0] r_rd;
            always_ff @(posedge clk) begin
                if (w_commit && !w_err && w_c_we && w_c_be[gi]) begin
                    r_mem[w_idx] <= w_c_wdata[8*gi +: 8];
                end
                if (w_commit && !w_err && !w_c_we) begin
                    r_rd <= r_mem[w_idx];
                end
            end
            assign w_rd_word[8*gi +: 8] = r_rd;
        end
    endgenerate

    assign rsp_valid = (r_state == ST_RESP);
    assign rsp_err   = r_rsp_err;
    assign rsp_rdata = r_rsp_load ? w_rd_word : 32'd0;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: one LATENCY=2 instance for the directed plan and one
// LATENCY=0 instance with a nonzero base for back-to-back and randomized traffic.
module tb_dmem_responder;

    logic              clk;
    logic              reset;
    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [1:0]        req_we;
    logic [1:0][31:0]  req_addr;
    logic [1:0][31:0]  req_wdata;
    logic [1:0][3:0]   req_be;
    logic [1:0]        rsp_valid;
    logic [1:0]        rsp_ready;
    logic [1:0][31:0]  rsp_rdata;
    logic [1:0]        rsp_err;

    int checks = 0;
    int errors = 0;

    logic [31:0] mdl   [2][1024];
    bit          known [2][1024];

    dmem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0000_0000), .LATENCY(2)) u_dut_a (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
    );

    dmem_responder #(.DEPTH_WORDS(64), .BASE_ADDR(32'h0000_0100), .LATENCY(0)) u_dut_b (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] base_of(input int d);
        return (d == 0) ? 32'h0000_0000 : 32'h0000_0100;
    endfunction

    function automatic int unsigned depth_of(input int d);
        return (d == 0) ? 1024 : 64;
    endfunction

    function automatic int lat_of(input int d);
        return (d == 0) ? 2 : 0;
    endfunction

    function automatic bit addr_err(input int d, input logic [31:0] a);
        logic [31:0] b;
        b = base_of(d);
        if (a[1:0] != 2'b00) return 1'b1;
        if (a < b) return 1'b1;
        return ((a - b) / 4) >= depth_of(d);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Full handshake: request, latency count, response content, hold, release.
    task automatic xact(input int d, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be,
                        input int hold, output logic [31:0] rd);
        int n;
        bit e;
        int idx;
        bit dchk;
        logic [31:0] exp_d;
        logic [31:0] held_d;
        logic held_e;
        e     = addr_err(d, addr);
        idx   = e ? 0 : int'((addr - base_of(d)) >> 2);
        dchk  = 1'b1;
        exp_d = 32'd0;
        if (!e && !we) begin
            exp_d = mdl[d][idx];
            dchk  = known[d][idx];
        end
        @(negedge clk);
        req_valid[d] = 1'b1;
        req_we[d]    = we;
        req_addr[d]  = addr;
        req_wdata[d] = wdata;
        req_be[d]    = be;
        rsp_ready[d] = 1'b0;
        n = 0;
        while (req_ready[d] !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("req_ready_idle", {31'd0, req_ready[d]}, 32'd1);
        @(negedge clk);
        req_valid[d] = 1'b0;
        req_we[d]    = ~we;
        req_addr[d]  = $urandom;
        req_wdata[d] = $urandom;
        req_be[d]    = 4'($urandom);
        n = 1;
        while (rsp_valid[d] !== 1'b1 && n < 40) begin
            check("req_ready_wait", {31'd0, req_ready[d]}, 32'd0);
            @(negedge clk);
            n++;
        end
        check("latency", n, lat_of(d) + 1);
        check("rsp_err", {31'd0, rsp_err[d]}, {31'd0, e});
        if (dchk) check("rsp_rdata", rsp_rdata[d], exp_d);
        held_d = rsp_rdata[d];
        held_e = rsp_err[d];
        rd     = rsp_rdata[d];
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            check("hold_valid", {31'd0, rsp_valid[d]}, 32'd1);
            check("hold_rdata", rsp_rdata[d], held_d);
            check("hold_err", {31'd0, rsp_err[d]}, {31'd0, held_e});
            check("hold_req_ready", {31'd0, req_ready[d]}, 32'd0);
        end
        rsp_ready[d] = 1'b1;
        @(negedge clk);
        rsp_ready[d] = 1'b0;
        check("clear_valid", {31'd0, rsp_valid[d]}, 32'd0);
        check("clear_rdata", rsp_rdata[d], 32'd0);
        check("clear_err", {31'd0, rsp_err[d]}, 32'd0);
        check("req_ready_after", {31'd0, req_ready[d]}, 32'd1);
        if (!e && we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mdl[d][idx][8*i +: 8] = wdata[8*i +: 8];
            end
            if (be == 4'hF) known[d][idx] = 1'b1;
        end
        $display("xact dut=%0d we=%0d addr=%h wdata=%h be=%h rdata=%h err=%0d cycles=%0d",
                 d, we, addr, wdata, be, rd, held_e, n);
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] a;
        int sel;
        reset     = 1'b1;
        req_valid = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        req_be    = '0;
        rsp_ready = '0;

        // Reset state of both instances
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check("rst_req_ready", {31'd0, req_ready[d]}, 32'd0);
            check("rst_rsp_valid", {31'd0, rsp_valid[d]}, 32'd0);
            check("rst_rsp_rdata", rsp_rdata[d], 32'd0);
            check("rst_rsp_err", {31'd0, rsp_err[d]}, 32'd0);
        end
        reset = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check("idle_req_ready", {31'd0, req_ready[d]}, 32'd1);
        end

        // Store then load, LATENCY=2
        xact(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, rd);
        check("store_rdata_zero", rd, 32'd0);
        xact(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, rd);
        check("load_after_store", rd, 32'hDEADBEEF);

        // Byte-lane merge
        xact(0, 1'b1, 32'h20, 32'h11223344, 4'hF, 0, rd);
        xact(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 0, rd);
        xact(0, 1'b0, 32'h20, 32'h0, 4'h0, 0, rd);
        check("be_merge", rd, 32'h11BB33DD);

        // Errors must leave RAM untouched, including the word an out-of-range index would alias
        xact(0, 1'b1, 32'h0, 32'hCAFEF00D, 4'hF, 0, rd);
        xact(0, 1'b1, 32'h40, 32'h5A5A5A5A, 4'hF, 0, rd);
        xact(0, 1'b0, 32'h22, 32'h0, 4'h0, 0, rd);
        xact(0, 1'b0, 32'h1000, 32'h0, 4'h0, 0, rd);
        xact(0, 1'b1, 32'h1000, 32'hFFFFFFFF, 4'hF, 0, rd);
        xact(0, 1'b1, 32'h42, 32'hFFFFFFFF, 4'hF, 0, rd);
        xact(0, 1'b0, 32'h40, 32'h0, 4'h0, 0, rd);
        check("no_side_effect_40", rd, 32'h5A5A5A5A);
        xact(0, 1'b0, 32'h0, 32'h0, 4'h0, 0, rd);
        check("no_side_effect_0", rd, 32'hCAFEF00D);

        // Back-pressure
        xact(0, 1'b0, 32'h10, 32'h0, 4'h0, 5, rd);

        // Reset while a store sits in WAIT
        xact(0, 1'b1, 32'h30, 32'h0, 4'hF, 0, rd);
        @(negedge clk);
        check("pre_rst_ready", {31'd0, req_ready[0]}, 32'd1);
        req_valid[0] = 1'b1;
        req_we[0]    = 1'b1;
        req_addr[0]  = 32'h30;
        req_wdata[0] = 32'hFFFFFFFF;
        req_be[0]    = 4'hF;
        @(negedge clk);
        req_valid[0] = 1'b0;
        check("wait_req_ready", {31'd0, req_ready[0]}, 32'd0);
        reset = 1'b1;
        #1;
        check("mid_rst_req_ready", {31'd0, req_ready[0]}, 32'd0);
        check("mid_rst_rsp_valid", {31'd0, rsp_valid[0]}, 32'd0);
        check("mid_rst_rsp_rdata", rsp_rdata[0], 32'd0);
        check("mid_rst_rsp_err", {31'd0, rsp_err[0]}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_req_ready", {31'd0, req_ready[0]}, 32'd1);
        check("post_rst_rsp_valid", {31'd0, rsp_valid[0]}, 32'd0);
        xact(0, 1'b0, 32'h30, 32'h0, 4'h0, 0, rd);
        check("lost_store", rd, 32'h0);

        // Preload every word of the LATENCY=0 instance
        for (int i = 0; i < 64; i++) begin
            xact(1, 1'b1, base_of(1) + 32'(4 * i), $urandom, 4'hF, 0, rd);
        end

        // Back-to-back loads with req_valid held high
        @(negedge clk);
        rsp_ready[1] = 1'b1;
        req_valid[1] = 1'b1;
        req_we[1]    = 1'b0;
        req_be[1]    = 4'h0;
        a = base_of(1);
        for (int c = 0; c < 10; c++) begin
            if (c % 2 == 0) begin
                a = base_of(1) + 32'(4 * $urandom_range(0, 63));
                req_addr[1] = a;
                check("b2b_req_ready_hi", {31'd0, req_ready[1]}, 32'd1);
                check("b2b_rsp_valid_lo", {31'd0, rsp_valid[1]}, 32'd0);
            end else begin
                check("b2b_req_ready_lo", {31'd0, req_ready[1]}, 32'd0);
                check("b2b_rsp_valid_hi", {31'd0, rsp_valid[1]}, 32'd1);
                check("b2b_rdata", rsp_rdata[1], mdl[1][int'((a - base_of(1)) >> 2)]);
                $display("b2b dut=1 addr=%h rdata=%h", a, rsp_rdata[1]);
            end
            @(negedge clk);
        end
        req_valid[1] = 1'b0;
        rsp_ready[1] = 1'b0;

        // Randomized traffic against the reference model
        for (int t = 0; t < 60; t++) begin
            sel = $urandom_range(0, 9);
            case (sel)
                0: a = base_of(1) + 32'(4 * $urandom_range(0, 63) + $urandom_range(1, 3));
                1: a = 32'($urandom_range(0, 255));
                2: a = base_of(1) + 32'(4 * (64 + $urandom_range(0, 15)));
                3: a = $urandom;
                default: a = base_of(1) + 32'(4 * $urandom_range(0, 63));
            endcase
            xact(1, 1'($urandom), a, $urandom, 4'($urandom), $urandom_range(0, 3), rd);
        end
        for (int t = 0; t < 20; t++) begin
            a = 32'(4 * $urandom_range(0, 31));
            xact(0, 1'($urandom), a, $urandom, 4'($urandom), $urandom_range(0, 2), rd);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
